// File: rtl/bus_cycle_seq.sv
// System-bus cycle sequencer: arbitrates for one bus interface unit, waits for its
// answer or times out, then times STROB1, optional single-step stop, STROB2 and GOT.
module bus_cycle_seq #(
  parameter int NCH           = 2,
  parameter int STROB1_TICKS  = 5,
  parameter int STROB2_TICKS  = 6,
  parameter int GOT_TICKS     = 5,
  parameter int ALARM_TICKS   = 250,
  parameter int RETRIES       = 0,
  parameter int STOP_ON_NOMEM = 1,
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            __clk,
  input  logic            clo_,
  input  logic            req,
  input  logic            req_w,
  input  logic            req_io,
  input  logic [SELW-1:0] ifsel,
  input  logic [NCH-1:0]  zw,
  input  logic [NCH-1:0]  rok_,
  input  logic [NCH-1:0]  ren_,
  input  logic [NCH-1:0]  rpe_,
  input  logic            mode_,
  input  logic            step_,
  input  logic            stop_,
  output logic [NCH-1:0]  zg,
  output logic            zwzg,
  output logic            strob1,
  output logic            strob2,
  output logic            got,
  output logic            done,
  output logic [1:0]      resp,
  output logic            alarm,
  output logic            awaria
);

  typedef enum logic [2:0] {IDLE, ZG, DRV, RETRY, S1, STEP, S2, GOT} state_t;

  localparam logic [1:0] RESP_OK    = 2'd0;
  localparam logic [1:0] RESP_EN    = 2'd1;
  localparam logic [1:0] RESP_PE    = 2'd2;
  localparam logic [1:0] RESP_ALARM = 2'd3;

  state_t          state, state_nxt;
  logic [9:0]      cnt, cnt_nxt;
  logic [1:0]      retry_cnt, retry_nxt;
  logic [SELW-1:0] sel, sel_nxt, sel_in;
  logic            cyc_w, cyc_w_nxt;
  logic            cyc_io, cyc_io_nxt;
  logic            step_prev;
  logic [1:0]      resp_nxt;
  logic            alarm_nxt, awaria_nxt, set_awaria;
  logic [NCH-1:0]  zg_nxt;
  logic            zwzg_nxt, strob1_nxt, strob2_nxt, got_nxt, done_nxt;
  logic            ans_ok, ans_en, ans_pe;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    retry_nxt  = retry_cnt;
    sel_nxt    = sel;
    cyc_w_nxt  = cyc_w;
    cyc_io_nxt = cyc_io;
    resp_nxt   = resp;
    alarm_nxt  = 1'b0;
    set_awaria = 1'b0;
    sel_in     = (32'(ifsel) < NCH) ? ifsel : '0;
    ans_ok     = ~rok_[sel];
    ans_en     = ~ren_[sel];
    ans_pe     = ~rpe_[sel];

    case (state)
      IDLE: begin
        if (req) begin
          state_nxt  = ZG;
          sel_nxt    = sel_in;
          cyc_w_nxt  = req_w;
          cyc_io_nxt = req_io;
          retry_nxt  = 2'd0;
        end
      end
      ZG: begin
        if (zw[sel]) begin
          state_nxt = DRV;
          cnt_nxt   = 10'd0;
        end
      end
      DRV: begin
        cnt_nxt = cnt + 10'd1;
        // An answer on the very clock the timeout expires still counts as an answer.
        if (ans_pe || ans_ok || ans_en) begin
          state_nxt  = S1;
          cnt_nxt    = 10'd0;
          resp_nxt   = ans_pe ? RESP_PE : (ans_ok ? RESP_OK : RESP_EN);
          set_awaria = ans_pe && !cyc_w;
        end else if (cnt == 10'(ALARM_TICKS - 1)) begin
          if (32'(retry_cnt) < RETRIES) begin
            state_nxt = RETRY;
            retry_nxt = retry_cnt + 2'd1;
          end else begin
            state_nxt  = S1;
            cnt_nxt    = 10'd0;
            resp_nxt   = RESP_ALARM;
            alarm_nxt  = 1'b1;
            set_awaria = (STOP_ON_NOMEM != 0) && !cyc_io;
          end
        end
      end
      RETRY: state_nxt = ZG;
      S1: begin
        cnt_nxt = cnt + 10'd1;
        if (cnt == 10'(STROB1_TICKS - 1)) begin
          state_nxt = mode_ ? S2 : STEP;
          cnt_nxt   = 10'd0;
        end
      end
      STEP: begin
        if (mode_ || (step_prev && !step_)) begin
          state_nxt = S2;
          cnt_nxt   = 10'd0;
        end
      end
      S2: begin
        cnt_nxt = cnt + 10'd1;
        if (cnt == 10'(STROB2_TICKS - 1)) begin
          state_nxt = GOT;
          cnt_nxt   = 10'd0;
        end
      end
      GOT: begin
        cnt_nxt = cnt + 10'd1;
        if (cnt == 10'(GOT_TICKS - 1)) begin
          state_nxt = IDLE;
          cnt_nxt   = 10'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 10'd0;
      end
    endcase

    // Outputs are decoded from the next state so that every output is a flop.
    zg_nxt = '0;
    if (state_nxt == ZG || state_nxt == DRV) zg_nxt[sel_nxt] = 1'b1;
    zwzg_nxt   = (state_nxt == DRV);
    strob1_nxt = (state_nxt == S1);
    strob2_nxt = (state_nxt == S2);
    got_nxt    = (state_nxt == GOT);
    done_nxt   = (state_nxt == GOT) && (cnt_nxt == 10'(GOT_TICKS - 1));
    awaria_nxt = set_awaria ? 1'b1 : (!stop_ ? 1'b0 : awaria);
  end

  always_ff @(posedge __clk) begin
    if (!clo_) begin
      state     <= IDLE;
      cnt       <= 10'd0;
      retry_cnt <= 2'd0;
      sel       <= '0;
      cyc_w     <= 1'b0;
      cyc_io    <= 1'b0;
      step_prev <= 1'b1;
      resp      <= RESP_OK;
      alarm     <= 1'b0;
      awaria    <= 1'b0;
      zg        <= '0;
      zwzg      <= 1'b0;
      strob1    <= 1'b0;
      strob2    <= 1'b0;
      got       <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      retry_cnt <= retry_nxt;
      sel       <= sel_nxt;
      cyc_w     <= cyc_w_nxt;
      cyc_io    <= cyc_io_nxt;
      step_prev <= step_;
      resp      <= resp_nxt;
      alarm     <= alarm_nxt;
      awaria    <= awaria_nxt;
      zg        <= zg_nxt;
      zwzg      <= zwzg_nxt;
      strob1    <= strob1_nxt;
      strob2    <= strob2_nxt;
      got       <= got_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_bus_cycle_seq.sv
// Directed testbench for bus_cycle_seq: NCH=2, ALARM_TICKS=8, RETRIES=1, default strobe
// lengths. Each bus cycle is tallied clock by clock and compared with hand-computed counts.
module tb_bus_cycle_seq;

  localparam int NCH  = 2;
  localparam int SELW = 1;

  logic            clk = 1'b0;
  logic            clo_;
  logic            req, req_w, req_io;
  logic [SELW-1:0] ifsel;
  logic [NCH-1:0]  zw, rok_, ren_, rpe_;
  logic            mode_, step_, stop_;
  logic [NCH-1:0]  zg;
  logic            zwzg, strob1, strob2, got, done, alarm, awaria;
  logic [1:0]      resp;

  int tests_run    = 0;
  int tests_failed = 0;

  int n_zg, zg_first, n_zwzg, n_s1, n_s2, n_got, n_alarm, n_gap, n_total;
  int n_overlap, n_badzg, done_seen, resp_at_done, awaria_at_done;

  always #5 clk = ~clk;

  bus_cycle_seq #(
    .NCH(NCH), .STROB1_TICKS(5), .STROB2_TICKS(6), .GOT_TICKS(5),
    .ALARM_TICKS(8), .RETRIES(1), .STOP_ON_NOMEM(1)
  ) dut (
    .__clk(clk), .clo_(clo_), .req(req), .req_w(req_w), .req_io(req_io),
    .ifsel(ifsel), .zw(zw), .rok_(rok_), .ren_(ren_), .rpe_(rpe_),
    .mode_(mode_), .step_(step_), .stop_(stop_), .zg(zg), .zwzg(zwzg),
    .strob1(strob1), .strob2(strob2), .got(got), .done(done), .resp(resp),
    .alarm(alarm), .awaria(awaria)
  );

  task automatic checkOutput(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Run one bus cycle: grant as soon as zg is seen, answer with 'ans' (bit0 OK, bit1 EN,
  // bit2 PE) in DRV round 'ans_round' (0 = never), and hold 'other' on the unselected channel.
  task automatic applyStimulus(input logic w, input logic io, input logic [SELW-1:0] sel,
                               input int ans_round, input logic [2:0] ans,
                               input logic [2:0] other);
    int round;
    logic prev_zwzg;
    logic [NCH-1:0] onehot;
    onehot = '0;
    onehot[sel] = 1'b1;
    n_zg = 0; n_zwzg = 0; n_s1 = 0; n_s2 = 0; n_got = 0; n_alarm = 0; n_gap = 0;
    n_total = 0; n_overlap = 0; n_badzg = 0; done_seen = 0; resp_at_done = -1;
    awaria_at_done = -1;
    req = 1'b1; req_w = w; req_io = io; ifsel = sel;
    tick;
    req = 1'b0;
    ifsel = ~sel;
    zg_first = int'(zg);
    round = 0;
    prev_zwzg = 1'b0;
    for (int i = 0; i < 200 && done_seen == 0; i++) begin
      n_total++;
      if (zg != '0) begin
        n_zg++;
        if (zg != onehot) n_badzg++;
      end
      if (zwzg) n_zwzg++;
      if (strob1) n_s1++;
      if (strob2) n_s2++;
      if (got) n_got++;
      if (alarm) n_alarm++;
      if (zg == '0 && !zwzg && !strob1 && !strob2 && !got) n_gap++;
      if (int'(zwzg) + int'(strob1) + int'(strob2) + int'(got) > 1) n_overlap++;
      if (zwzg && !prev_zwzg) round++;
      prev_zwzg = zwzg;
      if (done) begin
        done_seen = 1;
        resp_at_done = int'(resp);
        awaria_at_done = int'(awaria);
      end
      zw = zg;
      rok_ = '1; ren_ = '1; rpe_ = '1;
      if (zwzg) begin
        if (round == ans_round) begin
          rok_[sel] = ~ans[0]; ren_[sel] = ~ans[1]; rpe_[sel] = ~ans[2];
        end
        rok_[sel ^ 1'b1] = ~other[0]; ren_[sel ^ 1'b1] = ~other[1];
        rpe_[sel ^ 1'b1] = ~other[2];
      end
      if (!done) tick;
    end
    zw = '0; rok_ = '1; ren_ = '1; rpe_ = '1;
    tick;
  endtask

  task automatic checkCycle(input string tag, input int e_zg, input int e_zwzg,
                            input int e_total, input int e_gap, input int e_alarm,
                            input int e_resp, input int e_awaria);
    checkOutput({tag, "_done"}, done_seen, 1);
    checkOutput({tag, "_zg_clocks"}, n_zg, e_zg);
    checkOutput({tag, "_zwzg_clocks"}, n_zwzg, e_zwzg);
    checkOutput({tag, "_strob1_clocks"}, n_s1, 5);
    checkOutput({tag, "_strob2_clocks"}, n_s2, 6);
    checkOutput({tag, "_got_clocks"}, n_got, 5);
    checkOutput({tag, "_total_clocks"}, n_total, e_total);
    checkOutput({tag, "_gaps"}, n_gap, e_gap);
    checkOutput({tag, "_alarm_pulses"}, n_alarm, e_alarm);
    checkOutput({tag, "_resp"}, resp_at_done, e_resp);
    checkOutput({tag, "_awaria"}, awaria_at_done, e_awaria);
    checkOutput({tag, "_overlap"}, n_overlap, 0);
    checkOutput({tag, "_zg_onehot"}, n_badzg, 0);
  endtask

  task automatic clearAwaria(input string tag);
    stop_ = 1'b0;
    tick;
    stop_ = 1'b1;
    checkOutput(tag, int'(awaria), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int q, d, n2, ng, r;
    clo_ = 1'b0; req = 1'b0; req_w = 1'b0; req_io = 1'b0; ifsel = '0;
    zw = '0; rok_ = '1; ren_ = '1; rpe_ = '1;
    mode_ = 1'b1; step_ = 1'b1; stop_ = 1'b1;
    repeat (3) tick;
    clo_ = 1'b1;
    checkOutput("reset_outputs", int'({zg, zwzg, strob1, strob2, got, done, alarm, awaria, resp}), 0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1, 3'b001, 3'b000);
    checkOutput("read_ok_zg_value", zg_first, 2);
    checkCycle("read_ok", 2, 1, 18, 0, 0, 0, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1, 3'b010, 3'b000);
    checkOutput("write_en_zg_value", zg_first, 1);
    checkCycle("write_en", 2, 1, 18, 0, 0, 1, 0);

    applyStimulus(1'b0, 1'b0, 1'b0, 1, 3'b011, 3'b100);
    checkCycle("ok_over_en", 2, 1, 18, 0, 0, 0, 0);

    applyStimulus(1'b0, 1'b0, 1'b1, 1, 3'b111, 3'b000);
    checkCycle("prio_read", 2, 1, 18, 0, 0, 2, 1);
    clearAwaria("prio_read_awaria_clear");

    applyStimulus(1'b1, 1'b1, 1'b1, 1, 3'b111, 3'b000);
    checkCycle("prio_io_write", 2, 1, 18, 0, 0, 2, 0);

    applyStimulus(1'b0, 1'b0, 1'b0, 0, 3'b000, 3'b000);
    checkCycle("timeout_mem", 18, 16, 35, 1, 1, 3, 1);
    checkOutput("timeout_mem_awaria_sticky", int'(awaria), 1);
    clearAwaria("timeout_mem_awaria_clear");

    applyStimulus(1'b0, 1'b1, 1'b1, 0, 3'b000, 3'b000);
    checkCycle("timeout_io", 18, 16, 35, 1, 1, 3, 0);

    applyStimulus(1'b0, 1'b0, 1'b1, 2, 3'b001, 3'b000);
    checkCycle("retry_ok", 11, 9, 28, 1, 0, 0, 0);

    // Single step: step_ falls during STROB1, so the hold must wait for a fresh fall.
    mode_ = 1'b0;
    req = 1'b1; req_w = 1'b0; req_io = 1'b1; ifsel = 1'b0;
    tick;
    req = 1'b0;
    zw = 2'b01;
    tick;
    checkOutput("ss_zwzg", int'(zwzg), 1);
    rok_ = 2'b10;
    tick;
    zw = '0; rok_ = '1; step_ = 1'b0;
    q = 0;
    for (int i = 0; i < 5; i++) begin
      if (strob1) q++;
      tick;
    end
    checkOutput("ss_strob1_clocks", q, 5);
    q = 0;
    for (int i = 0; i < 3; i++) begin
      if ({zg, zwzg, strob1, strob2, got, done} == '0) q++;
      tick;
    end
    checkOutput("ss_hold_low_quiet", q, 3);
    step_ = 1'b1;
    tick;
    checkOutput("ss_release_quiet", int'({zg, zwzg, strob1, strob2, got, done}), 0);
    step_ = 1'b0;
    tick;
    checkOutput("ss_strob2_start", int'(strob2), 1);
    step_ = 1'b1;
    n2 = 0; ng = 0; r = -1; d = 0;
    for (int i = 0; i < 40 && d == 0; i++) begin
      if (strob2) n2++;
      if (got) ng++;
      if (done) begin
        d = 1;
        r = int'(resp);
      end else tick;
    end
    checkOutput("ss_strob2_clocks", n2, 6);
    checkOutput("ss_got_clocks", ng, 5);
    checkOutput("ss_resp", r, 0);
    tick;
    mode_ = 1'b1;

    // Reset while the bus is owned, then a normal cycle.
    req = 1'b1; req_w = 1'b0; req_io = 1'b0; ifsel = 1'b1;
    tick;
    req = 1'b0;
    zw = 2'b10;
    tick;
    checkOutput("rst_drv_entry", int'(zwzg), 1);
    tick;
    clo_ = 1'b0;
    tick;
    clo_ = 1'b1;
    zw = '0;
    checkOutput("rst_mid_outputs", int'({zg, zwzg, strob1, strob2, got, done, alarm, awaria, resp}), 0);
    d = 0;
    for (int i = 0; i < 25; i++) begin
      if (done || zg != '0) d++;
      tick;
    end
    checkOutput("rst_no_done", d, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1, 3'b001, 3'b000);
    checkCycle("after_reset", 2, 1, 18, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
